// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Holds instruction width, PC step, default reset PC and the queue entry type.
package ifu_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_INCR     = 4;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue.sv
// fetch_queue: synchronous FIFO with flush used as the prefetch queue.
// Ports: clk, rst_n, i_push, i_pop, i_flush, i_wdata -> o_rdata, o_count, o_full, o_empty.
module fetch_queue #(
   parameter int QUEUE_DEPTH = 4,
   parameter int ENTRY_W     = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_push,
   input  logic                           i_pop,
   input  logic                           i_flush,
   input  logic [ENTRY_W-1:0]             i_wdata,
   output logic [ENTRY_W-1:0]             o_rdata,
   output logic [$clog2(QUEUE_DEPTH):0]   o_count,
   output logic                           o_full,
   output logic                           o_empty
);

   localparam int QPTR_BITS = $clog2(QUEUE_DEPTH);
   localparam logic [QPTR_BITS:0] DEPTH_C = (QPTR_BITS+1)'(QUEUE_DEPTH);

   logic [ENTRY_W-1:0]   r_mem [QUEUE_DEPTH];
   logic [QPTR_BITS-1:0] r_rd_ptr;
   logic [QPTR_BITS-1:0] r_wr_ptr;
   logic [QPTR_BITS:0]   r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally since the depth is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (i_push && !i_pop) begin
            r_count <= r_count + 1'b1;
         end else if (i_pop && !i_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == DEPTH_C);
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns fetch PC, reads imem, queues {pc,instr} for decode.
// Ports: clk, rst_n, fetch_en, imem_addr/imem_rdata, redirect_valid/redirect_pc,
// out_valid/out_ready/out_pc/out_instr; perf_fetch_cnt/perf_flush_cnt with IFU_PERF_CNT_EN.
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC),
   parameter int                    QUEUE_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fetch_en,
   output logic [ADDR_WIDTH-1:0]   imem_addr,
   input  logic [INSTR_WIDTH-1:0]  imem_rdata,
   input  logic                    redirect_valid,
   input  logic [ADDR_WIDTH-1:0]   redirect_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ADDR_WIDTH-1:0]   out_pc,
   output logic [INSTR_WIDTH-1:0]  out_instr
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]             perf_fetch_cnt,
   output logic [31:0]             perf_flush_cnt
`endif
);

   localparam int QPTR_BITS = $clog2(QUEUE_DEPTH);
   localparam int ENTRY_W   = ADDR_WIDTH + INSTR_WIDTH;

   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [QPTR_BITS:0]    w_count;
   logic [ENTRY_W-1:0]    w_head;

   assign w_pop  = out_valid && out_ready;
   // A full queue still accepts a word when the head leaves this cycle.
   assign w_push = fetch_en && !redirect_valid && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         r_fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(PC_INCR);
      end
   end

   assign imem_addr = r_fetch_pc;

   fetch_queue #(
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .ENTRY_W     (ENTRY_W)
   ) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_wdata ({r_fetch_pc, imem_rdata}),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign out_valid = !w_empty;
   assign out_pc    = w_head[ENTRY_W-1 -: ADDR_WIDTH];
   assign out_instr = w_head[INSTR_WIDTH-1:0];

`ifdef IFU_PERF_CNT_EN
   logic r_unused_lsb;
   logic w_discard;

   // A flush discards nothing when the queue is empty or its only entry is popped.
   assign w_discard = redirect_valid && (w_count != '0) &&
                      !((w_count == (QPTR_BITS+1)'(1)) && w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
         r_unused_lsb   <= 1'b0;
      end else begin
         if (w_push) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (w_discard) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
         r_unused_lsb <= ^redirect_pc[1:0];
      end
   end
`else
   logic w_unused;
   assign w_unused = ^{redirect_pc[1:0], w_count};
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit against a queue-level model.
// Directed steps followed by randomized traffic; perf counters checked with IFU_PERF_CNT_EN.
module tb_instruction_fetch_unit;
   import ifu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int n_total;
   int n_pass;

   fetch_entry_t m_q[$];
   logic [31:0]  m_pc;
   int unsigned  m_fetch;
   int unsigned  m_flush;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   instruction_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc    = 32'h0;
      m_fetch = 0;
      m_flush = 0;
   endtask

   // Compare the DUT against the model; called between clock edges.
   task automatic check_state();
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) begin
         chk("out_pc", out_pc, m_q[0].pc);
         chk("out_instr", out_instr, m_q[0].instr);
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, m_fetch);
      chk("perf_flush", perf_flush_cnt, m_flush);
`endif
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model, check.
   task automatic cyc(input logic fe, input logic rdy, input logic rv,
                      input logic [31:0] rpc);
      int  sz;
      bit  pop;
      fetch_entry_t e;
      fetch_en       = fe;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      sz  = m_q.size();
      pop = (sz != 0) && rdy;
      if (rv) begin
         if (sz > 1 || (sz == 1 && !pop)) m_flush++;
         m_q.delete();
         m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (fe && (sz < 4 || pop)) begin
            e.pc    = m_pc;
            e.instr = mem_word(m_pc);
            m_q.push_back(e);
            m_pc = m_pc + 32'd4;
            m_fetch++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_state();
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      model_reset();

      #3;
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming from reset: one instruction per cycle.
      for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0);

      // Asynchronous reset mid-cycle clears everything at once.
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_addr", imem_addr, 32'h0);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_pc", out_pc, 32'h0);
      chk("mid_rst_instr", out_instr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill with decode stalled; address must stop at 0x10.
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
      chk("full_addr_hold", imem_addr, 32'h10);
      chk("full_head", out_pc, 32'h0);
      for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);

      // Redirect to 0x23 with no pop: queue flushed, restart at 0x20.
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'h23);
      chk("redir_addr", imem_addr, 32'h20);
      cyc(1, 1, 0, 0);
      chk("redir_first_pc", out_pc, 32'h20);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
      // Redirect together with a pop: head consumed, rest discarded.
      cyc(1, 1, 1, 32'h100);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);

      // fetch_en low for three cycles: PC holds, queue drains.
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);

      // Address wrap past the top of memory.
      cyc(1, 1, 1, 32'hFFFF_FFF8);
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);

      // Back-to-back redirects: the last one wins.
      cyc(1, 1, 1, 32'h400);
      cyc(1, 1, 1, 32'h800);
      chk("b2b_addr", imem_addr, 32'h800);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic        fe;
         logic        rdy;
         logic        rv;
         logic [31:0] rpc;
         fe  = ($urandom_range(0, 9) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 15) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                           : $urandom;
         cyc(fe, rdy, rv, rpc);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
